// File: rtl/internal_framebuffer_pkg.sv
// Shared types and width helpers for the internal framebuffer load/commit paths.
// Used by the loader and the command handler.
package internal_framebuffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int mem_addr_width(input int fb_lg, input int ppb);
        return fb_lg - $clog2(ppb);
    endfunction

    function automatic int mask_width(input int ppb, input int nsub);
        return ppb * nsub;
    endfunction

    function automatic int bytes_per_pixel(input int nsub, input int spw);
        return (nsub * spw) / 8;
    endfunction

endpackage

// File: rtl/internal_framebuffer_loader.sv
// Loads framebuffer content from external memory into the internal RAM:
// one read request, then stream beats written sequentially to the RAM port.
module internal_framebuffer_loader
    import internal_framebuffer_pkg::*;
#(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 2,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int FB_SIZE_IN_PIXEL_LG          = 20,
    parameter int ADDR_WIDTH                   = 32,
    localparam int PIXEL_WIDTH    = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int STREAM_WIDTH   = NUMBER_OF_PIXELS_PER_BEAT * PIXEL_WIDTH,
    localparam int MASK_WIDTH     = mask_width(NUMBER_OF_PIXELS_PER_BEAT,
                                               NUMBER_OF_SUB_PIXELS),
    localparam int MEM_ADDR_WIDTH = mem_addr_width(FRAMEBUFFER_SIZE_IN_PIXEL_LG,
                                                   NUMBER_OF_PIXELS_PER_BEAT)
) (
    input  logic                            aclk,
    input  logic                            resetn,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    output logic                            applied,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
    input  logic [ADDR_WIDTH-1:0]           cmdAddr,
    output logic                            m_avalid,
    output logic [ADDR_WIDTH-1:0]           m_aaddr,
    output logic [ADDR_WIDTH-1:0]           m_abytes,
    input  logic                            m_aready,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]         s_axis_tdata,
    input  logic [MASK_WIDTH-1:0]           s_axis_tstrb,
    output logic                            writeEnablePort,
    output logic [MEM_ADDR_WIDTH-1:0]       writeAddrPort,
    output logic [STREAM_WIDTH-1:0]         writeDataPort,
    output logic [MASK_WIDTH-1:0]           writeMaskPort
);

    localparam int PPB_LG = $clog2(NUMBER_OF_PIXELS_PER_BEAT);
    localparam int BPP    = bytes_per_pixel(NUMBER_OF_SUB_PIXELS,
                                            SUB_PIXEL_WIDTH);

    state_t                    r_state;
    state_t                    w_next_state;

    logic                      r_avalid;
    logic [ADDR_WIDTH-1:0]     r_aaddr;
    logic [ADDR_WIDTH-1:0]     r_abytes;

    logic [MEM_ADDR_WIDTH-1:0] r_index;
    logic [MEM_ADDR_WIDTH-1:0] r_size_beats;

    logic                      r_we;
    logic [MEM_ADDR_WIDTH-1:0] r_waddr;
    logic [STREAM_WIDTH-1:0]   r_wdata;
    logic [MASK_WIDTH-1:0]     r_wmask;

    logic [MEM_ADDR_WIDTH-1:0] w_size_beats;
    logic [ADDR_WIDTH-1:0]     w_bytes;
    logic                      w_start;
    logic                      w_tready;
    logic                      w_hs;
    logic                      w_wr_hs;
    logic                      w_last_count;

    assign w_size_beats = MEM_ADDR_WIDTH'(cmdSize >> PPB_LG);
    assign w_bytes      = ADDR_WIDTH'(cmdSize) * ADDR_WIDTH'(BPP);

    assign w_start = (r_state == IDLE) && apply && !r_avalid
                     && (w_size_beats != '0);

    assign w_hs         = s_axis_tvalid && w_tready;
    assign w_wr_hs      = w_hs && (r_state == RECV);
    assign w_last_count = (r_index + 1'b1) == r_size_beats;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = RECV;
                end
            end
            RECV: begin
                w_tready = 1'b1;
                // A short stream (early tlast) ends the load as well.
                if (w_hs) begin
                    if (s_axis_tlast) begin
                        w_next_state = IDLE;
                    end else if (w_last_count) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_tready = 1'b1;
                if (w_hs && s_axis_tlast) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // The request can still be pending while beats are already arriving.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_avalid <= 1'b0;
        end else if (r_avalid && m_aready) begin
            r_avalid <= 1'b0;
        end else if (w_start) begin
            r_avalid <= 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_start) begin
            r_aaddr  <= cmdAddr;
            r_abytes <= w_bytes;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_index <= '0;
        end else begin
            r_we <= w_wr_hs;
            if (r_state == IDLE) begin
                r_index <= '0;
            end else if (w_wr_hs) begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (r_state == IDLE) begin
            r_size_beats <= w_size_beats;
        end
        if (w_wr_hs) begin
            r_waddr <= r_index;
            r_wdata <= s_axis_tdata;
            r_wmask <= s_axis_tstrb
                       & {NUMBER_OF_PIXELS_PER_BEAT{confMask}};
        end
    end

    assign applied         = (r_state == IDLE) && !r_avalid;
    assign m_avalid        = r_avalid;
    assign m_aaddr         = r_aaddr;
    assign m_abytes        = r_abytes;
    assign s_axis_tready   = w_tready;
    assign writeEnablePort = r_we;
    assign writeAddrPort   = r_waddr;
    assign writeDataPort   = r_wdata;
    assign writeMaskPort   = r_wmask;

endmodule

// File: doc/internal_framebuffer_loader.md
Name: internal_framebuffer_loader

Overview:
- Counterpart of the framebuffer commit path: it loads framebuffer content from external memory into the internal framebuffer RAM.
- On a load command it issues one read request (address plus byte count) to the memory bridge.
- It then accepts the returned AXI-Stream beats and writes them sequentially into the internal RAM write port, applying tstrb and the colour mask.
- It sits beside the command handler on the same RAM write port, which the top level arbitrates by the `applied` flags.

Parameters:
- NUMBER_OF_PIXELS_PER_BEAT, 2, pixels per stream beat / RAM word
- NUMBER_OF_SUB_PIXELS, 4, sub pixels per pixel
- SUB_PIXEL_WIDTH, 8, bits per sub pixel
- FRAMEBUFFER_SIZE_IN_PIXEL_LG, 18, log2 of internal RAM size in pixels
- FB_SIZE_IN_PIXEL_LG, 20, width of cmdSize
- ADDR_WIDTH, 32, external address/byte-count width
- Derived localparams:
  - PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH
  - STREAM_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * PIXEL_WIDTH
  - MASK_WIDTH = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS
  - MEM_ADDR_WIDTH = FRAMEBUFFER_SIZE_IN_PIXEL_LG - clog2(NUMBER_OF_PIXELS_PER_BEAT)

Ports:
- aclk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- confMask  in  NUMBER_OF_SUB_PIXELS  per-sub-pixel write enable
- apply  in  1  start load command (level, sampled in IDLE)
- applied  out  1  high when idle and no request outstanding
- cmdSize  in  FB_SIZE_IN_PIXEL_LG  load size in pixels
- cmdAddr  in  ADDR_WIDTH  external source address
- m_avalid  out  1  read request valid
- m_aaddr  out  ADDR_WIDTH  request address
- m_abytes  out  ADDR_WIDTH  request length in bytes
- m_aready  in  1  request accepted
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  last beat
- s_axis_tdata  in  STREAM_WIDTH  pixel data, pixel 0 in LSBs
- s_axis_tstrb  in  MASK_WIDTH  per-sub-pixel strobe
- writeEnablePort  out  1  RAM write enable
- writeAddrPort  out  MEM_ADDR_WIDTH  RAM word address
- writeDataPort  out  STREAM_WIDTH  RAM write data
- writeMaskPort  out  MASK_WIDTH  RAM sub-pixel write mask

Behaviour:
- Reset values: m_avalid=0, applied=1, s_axis_tready=0, writeEnablePort=0, state=IDLE, beat counter=0. Other data outputs are don't-care.
- Beat count: sizeBeats = cmdSize >> clog2(PIXELS_PER_BEAT), truncated to MEM_ADDR_WIDTH bits and latched in IDLE.
- Byte count: m_abytes = cmdSize * (PIXEL_WIDTH/8), zero-extended to ADDR_WIDTH.
- IDLE:
  - writeEnablePort=0, index=0, s_axis_tready=0.
  - If apply && !m_avalid && sizeBeats!=0: applied<=0, m_avalid<=1, m_aaddr<=cmdAddr, m_abytes<=bytes, go to RECV.
  - If apply && sizeBeats==0: no request issued, applied stays 1, stay in IDLE.
- m_avalid clears on the cycle after m_avalid && m_aready, independent of state. RECV may overlap with a pending request.
- RECV:
  - s_axis_tready=1.
  - Each handshake (tvalid && tready) registers a write that appears on the next cycle: writeEnablePort=1, writeAddrPort=index, writeDataPort=tdata, writeMaskPort=tstrb & {PIXELS_PER_BEAT{confMask}}. index increments.
  - No handshake: writeEnablePort=0 on the next cycle.
  - Write latency is exactly 1 cycle from the handshake.
- Completion:
  - On the handshake where index+1==sizeBeats: if tlast, go to IDLE; else go to DRAIN.
  - On a handshake with tlast before the count is reached (short stream): the beat is written, then go to IDLE.
- DRAIN:
  - s_axis_tready=1, no RAM writes.
  - Beats are discarded until a handshake with tlast, then go to IDLE.
- applied rises the first cycle the block is in IDLE with m_avalid==0. Thus the final RAM write (issued the cycle after the last handshake) coincides with the first IDLE cycle, and applied is asserted no earlier than that cycle.
- RAM address wrap: index never exceeds sizeBeats-1, so no wrap. A cmdSize larger than the RAM is the caller's error; the index wraps modulo 2^MEM_ADDR_WIDTH.
- Reset mid-operation: return to IDLE within one cycle, drop m_avalid, stop writes. No stream drain is done; the upstream is reset together with this block.
- apply asserted while not in IDLE is ignored.

Decomposition:
- A shared package (internal_framebuffer_pkg) holds:
  - state encodings IDLE/RECV/DRAIN
  - the derived-width localparam functions (MEM_ADDR_WIDTH, MASK_WIDTH)
  - the bytes-per-pixel computation, also used by the command handler
- No sub-module. The stream-to-RAM write stage is a single registered process in this module.

Test Plan:
- Basic load: cmdSize=8, cmdAddr=0x1000; m_aready on cycle 2; 4 beats, tlast on beat 3, tstrb=0xFF, confMask=0xF.
  - m_abytes=32, m_aaddr=0x1000.
  - Writes to addrs 0..3, each 1 cycle after its handshake, mask 0xFF.
  - applied=1 after the last write.
- Backpressure/gaps: same load with tvalid toggling every other cycle -> 4 writes only, correct addrs, writeEnablePort=0 in the gap cycles.
- Mask: confMask=0x5, tstrb=0xF0 -> writeMaskPort=0x50 on every write.
- Short stream: cmdSize=8, tlast on beat 1 -> two writes (addrs 0,1), return to IDLE, applied=1.
- Long stream: cmdSize=4, 5 beats with tlast on beat 4 -> writes on addrs 0,1 only, beats 2..4 accepted and discarded, then IDLE.
- Zero size / reset:
  - cmdSize=1 with PIXELS_PER_BEAT=2 -> no m_avalid, applied stays 1.
  - resetn low mid-RECV -> next cycle m_avalid=0, writeEnablePort=0, applied=1.
